sort_sequencer: RTL and testbench

//   Multi-cycle sorting engine with valid/ready handshakes; the area-lean counterpart to the single-cycle

---
 rtl/sort_sequencer_if.sv | 25 ++
 rtl/sort_sequencer.sv | 131 +++++++++++++
 tb/tb_sort_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sort_sequencer_if.sv
// Handshake bundle for the sequential sorter: input vector channel, output
// vector channel and the busy indicator. The producer/consumer side uses the
// master modport, the sorting engine uses the slave modport.
interface sort_sequencer_if #(
   parameter int BW = 8,
   parameter int N  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [N*BW-1:0]   in_data;
   logic              out_valid;
   logic              out_ready;
   logic [N*BW-1:0]   out_data;
   logic              busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/sort_sequencer.sv
// Multi-cycle odd-even transposition sorter. A vector is captured in IDLE,
// one compare-exchange phase runs per clock in SORT, and the ascending result
// is held in DONE until the consumer takes it.
// Optional feature macro: SORT_SEQ_EARLY_EXIT_EN -- when defined, the engine
// leaves SORT as soon as two consecutive phases made no swap.
module sort_sequencer #(
   parameter int BW = 8,
   parameter int N  = 8
) (
   input  logic           clk,
   input  logic           rstn,
   sort_sequencer_if.slave bus
);

   localparam int PW = $clog2(N + 1);

   generate
      if (N < 2) begin : g_bad_n
         $error("sort_sequencer: N must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pass_q, pass_d;
   logic [BW-1:0] arr_q [N];
   logic [BW-1:0] arr_d [N];
   logic [BW-1:0] phase_arr [N];
`ifdef SORT_SEQ_EARLY_EXIT_EN
   logic          swapped;
   logic          quiet_q, quiet_d;
`endif

   // One transposition phase: even passes pair (0,1),(2,3)..., odd passes (1,2),(3,4)...
   always_comb begin
      phase_arr = arr_q;
`ifdef SORT_SEQ_EARLY_EXIT_EN
      swapped = 1'b0;
`endif
      for (int l = 0; l < N - 1; l++) begin
         if ((l % 2) == int'(pass_q[0])) begin
            if (arr_q[l] > arr_q[l+1]) begin
               phase_arr[l]   = arr_q[l+1];
               phase_arr[l+1] = arr_q[l];
`ifdef SORT_SEQ_EARLY_EXIT_EN
               swapped = 1'b1;
`endif
            end
         end
      end
   end

   // Next-state, pass counter and array update for the IDLE/SORT/DONE controller
   always_comb begin
      state_d = state_q;
      pass_d  = pass_q;
      arr_d   = arr_q;
`ifdef SORT_SEQ_EARLY_EXIT_EN
      quiet_d = quiet_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               for (int i = 0; i < N; i++) begin
                  arr_d[i] = bus.in_data[i*BW +: BW];
               end
               pass_d  = '0;
`ifdef SORT_SEQ_EARLY_EXIT_EN
               quiet_d = 1'b0;
`endif
               state_d = SORT;
            end
         end
         SORT: begin
            arr_d  = phase_arr;
            pass_d = pass_q + PW'(1);
            if (pass_q == PW'(N - 1)) begin
               state_d = DONE;
            end
`ifdef SORT_SEQ_EARLY_EXIT_EN
            quiet_d = !swapped;
            if ((pass_q != '0) && !swapped && quiet_q) begin
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and array registers; reset discards any vector in flight
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         pass_q  <= '0;
         for (int i = 0; i < N; i++) begin
            arr_q[i] <= '0;
         end
`ifdef SORT_SEQ_EARLY_EXIT_EN
         quiet_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
         arr_q   <= arr_d;
`ifdef SORT_SEQ_EARLY_EXIT_EN
         quiet_q <= quiet_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q == SORT);
   assign bus.out_valid = (state_q == DONE);

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_out
         assign bus.out_data[g*BW +: BW] = arr_q[g];
      end
   endgenerate

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer (BW=8, N=8) with hand-computed results,
// plus a small reference sort for the back-to-back random vectors.
module tb_sort_sequencer;

   localparam int BW = 8;
   localparam int N  = 8;
`ifdef SORT_SEQ_EARLY_EXIT_EN
   localparam int LAT_SORTED = 2;
`else
   localparam int LAT_SORTED = N;
`endif

   logic clk;
   logic rstn;
   int   totalChecks = 0;
   int   badChecks   = 0;
   int   cyc         = 0;

   sort_sequencer_if #(.BW(BW), .N(N)) bus ();

   sort_sequencer #(.BW(BW), .N(N)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to time handshakes
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] pk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
      return {e7, e6, e5, e4, e3, e2, e1, e0};
   endfunction

   function automatic logic [63:0] refSort(input logic [63:0] v);
      logic [7:0] a [8];
      logic [7:0] t;
      logic [63:0] r;
      for (int i = 0; i < 8; i++) a[i] = v[i*8 +: 8];
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 7 - i; j++)
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
      for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Present a vector for exactly one rising edge; engine must be in IDLE
   task automatic applyStimulus(input logic [63:0] vec);
      bus.in_data  = vec;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   // Count rising edges until out_valid is seen, bounded
   task automatic waitOut(output int edges);
      edges = 0;
      while (bus.out_valid !== 1'b1 && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic sortOne(input string tag, input logic [63:0] vec, input logic [63:0] expected,
                          output int edges);
      applyStimulus(vec);
      checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd1);
      waitOut(edges);
      checkOutput({tag, "_data"}, bus.out_data, expected);
   endtask

   initial begin
      int edges;
      int guard;
      bit hs;
      bit rdy;
      int hsCycle [3];
      logic [63:0] vecs [3];
      logic [63:0] held;

      rstn          = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("rst_out_data", bus.out_data, 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Reversed vector; handshake is edge 1 after release, out_valid after edge 9
      sortOne("rev", pk(7,6,5,4,3,2,1,0), pk(0,1,2,3,4,5,6,7), edges);
`ifdef SORT_SEQ_EARLY_EXIT_EN
      checkOutput("rev_lat", 64'(edges <= N), 64'd1);
`else
      checkOutput("rev_lat", 64'(edges), 64'(N));
`endif
      @(posedge clk);
      #1;
      checkOutput("rev_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("rev_out_valid", 64'(bus.out_valid), 64'd0);

      // Duplicates and unsigned extremes
      sortOne("dup", pk(3,1,3,0,255,1,0,255), pk(0,0,1,1,3,3,255,255), edges);
      @(posedge clk);
      #1;

      // Backpressure: hold result for five cycles while in_valid pulses are ignored
      bus.out_ready = 1'b0;
      sortOne("bp", pk(5,200,17,17,0,99,42,8), pk(0,5,8,17,17,42,99,200), edges);
      held = pk(0,5,8,17,17,42,99,200);
      for (int c = 0; c < 5; c++) begin
         bus.in_valid = c[0] ? 1'b0 : 1'b1;
         bus.in_data  = pk(1,1,1,1,1,1,1,1);
         @(posedge clk);
         #1;
         checkOutput("bp_valid", 64'(bus.out_valid), 64'd1);
         checkOutput("bp_data", bus.out_data, held);
         checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_release_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("bp_release_valid", 64'(bus.out_valid), 64'd0);

      // Reset in the middle of SORT at pass 3
      applyStimulus(pk(40,30,20,10,0,1,2,3));
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
      checkOutput("midrst_data", bus.out_data, 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      sortOne("after_rst", pk(9,8,7,6,5,4,3,2), pk(2,3,4,5,6,7,8,9), edges);
      @(posedge clk);
      #1;

      // Already-sorted input
      sortOne("sorted", pk(0,1,2,3,4,5,6,7), pk(0,1,2,3,4,5,6,7), edges);
      checkOutput("sorted_lat", 64'(edges), 64'(LAT_SORTED));
      @(posedge clk);
      #1;

      // Back-to-back with in_valid held high
      for (int k = 0; k < 3; k++) vecs[k] = {$urandom, $urandom};
      bus.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.in_data = vecs[k];
         hs = 1'b0;
         guard = 0;
         while (!hs && guard < 50) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            guard++;
            hs = rdy;
         end
         hsCycle[k] = cyc;
         checkOutput("b2b_handshake", 64'(hs), 64'd1);
         #1;
         if (k == 2) bus.in_valid = 1'b0;
         waitOut(edges);
         checkOutput("b2b_data", bus.out_data, refSort(vecs[k]));
`ifndef SORT_SEQ_EARLY_EXIT_EN
         if (k > 0) checkOutput("b2b_spacing", 64'(hsCycle[k] - hsCycle[k-1]), 64'(N + 2));
`endif
      end
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
